// File: rtl/lattice_stream_out_if.sv
// AXI4-Stream bundle for the lattice write-back stream.
// Master drives the beat, slave drives tready.
interface lattice_stream_out_if #(
    parameter int DATA_WIDTH = 16
);
    localparam int TW = 9 * DATA_WIDTH;

    logic          tvalid;
    logic          tready;
    logic [TW-1:0] tdata;
    logic [TW/8-1:0] tstrb;
    logic          tlast;

    modport master (
        output tvalid,
        output tdata,
        output tstrb,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tstrb,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/lattice_stream_out.sv
// Streams 9 lattice-direction words per pixel out of BRAM as AXIS beats.
// Optional LATTICE_STREAM_OUT_CHECKSUM_EN adds an XOR checksum output.
module lattice_stream_out #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 2500,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     m00_axis_aclk,
    input  logic                     m00_axis_aresetn,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [ADDRESS_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]    n_rd,
    input  logic [DATA_WIDTH-1:0]    null_rd,
    input  logic [DATA_WIDTH-1:0]    ne_rd,
    input  logic [DATA_WIDTH-1:0]    e_rd,
    input  logic [DATA_WIDTH-1:0]    se_rd,
    input  logic [DATA_WIDTH-1:0]    s_rd,
    input  logic [DATA_WIDTH-1:0]    sw_rd,
    input  logic [DATA_WIDTH-1:0]    w_rd,
    input  logic [DATA_WIDTH-1:0]    nw_rd,
`ifdef LATTICE_STREAM_OUT_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0]    checksum,
`endif
    lattice_stream_out_if.master     m00_axis
);
    localparam int TW = 9 * DATA_WIDTH;
    localparam int CW = ADDRESS_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   issued;
    logic [CW-1:0]   beat;
    logic [1:0]      count;
    logic            in_flight;
    logic [TW-1:0]   buf_q [2];
    logic            head;
    logic            tail;
    logic            pop;
    logic            push;
    logic            accept;
    logic            last_pop;
    logic [2:0]      occ;
    logic [TW-1:0]   lanes;

    assign lanes = {nw_rd, w_rd, sw_rd, s_rd, se_rd,
                    e_rd, ne_rd, null_rd, n_rd};

    assign push     = in_flight;
    assign pop      = m00_axis.tvalid & m00_axis.tready;
    assign accept   = (state == IDLE) & start;
    assign last_pop = pop & m00_axis.tlast;
    assign busy     = (state != IDLE);

    assign m00_axis.tvalid = (count != 2'd0);
    assign m00_axis.tdata  = buf_q[head];
    assign m00_axis.tstrb  = '1;
    assign m00_axis.tlast  = m00_axis.tvalid &
                             (beat == CW'(DEPTH - 1));

    // Credit rule: never let buffered plus in-flight reads exceed two.
    assign occ   = {1'b0, count} + {2'b00, in_flight};
    assign rd_en = (state == STREAM) &
                   (issued < CW'(DEPTH)) &
                   (occ < (3'd2 + {2'b00, pop}));

    assign rd_addr = (issued >= CW'(DEPTH)) ?
                     ADDRESS_WIDTH'(DEPTH - 1) :
                     issued[ADDRESS_WIDTH-1:0];

    // State register.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: issue until all reads sent, then drain to tlast.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = STREAM;
            end
            STREAM: begin
                if (last_pop) begin
                    state_nx = IDLE;
                end else if (issued == CW'(DEPTH)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Read issue, beat counting and the completion pulse.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            issued    <= '0;
            beat      <= '0;
            in_flight <= 1'b0;
            done      <= 1'b0;
        end else begin
            in_flight <= rd_en;
            done      <= last_pop;
            if (accept) begin
                issued <= '0;
            end else if (rd_en) begin
                issued <= issued + 1'b1;
            end
            if (accept) begin
                beat <= '0;
            end else if (pop) begin
                beat <= beat + 1'b1;
            end
        end
    end

    // Two-entry FIFO: BRAM data lands in the tail, head drives tdata.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            for (int i = 0; i < 2; i++) buf_q[i] <= '0;
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                buf_q[tail] <= lanes;
                tail        <= ~tail;
            end
            if (pop) head <= ~head;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef LATTICE_STREAM_OUT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] fold;

    // XOR of the nine lanes of the beat at the head.
    always_comb begin
        fold = '0;
        for (int i = 0; i < 9; i++) begin
            fold = fold ^ m00_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Running checksum over every popped beat of the frame.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum ^ fold;
        end
    end
`endif

endmodule

// File: tb/tb_lattice_stream_out.sv
// Directed bench for lattice_stream_out with a 1-cycle BRAM model.
// Covers flow, backpressure, stalls, start-while-busy and mid-frame reset.
module tb_lattice_stream_out;
    localparam int DW    = 16;
    localparam int DEPTH = 2500;
    localparam int AW    = 12;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] lane [9];
`ifdef LATTICE_STREAM_OUT_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    int            total;
    int            bad;
    logic [15:0]   cks_exp;

    lattice_stream_out_if #(.DATA_WIDTH(DW)) axis ();

    lattice_stream_out #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .ADDRESS_WIDTH(AW)
    ) dut (
        .m00_axis_aclk(clk),
        .m00_axis_aresetn(rst_n),
        .start(start),
        .busy(busy),
        .done(done),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .n_rd(lane[0]),
        .null_rd(lane[1]),
        .ne_rd(lane[2]),
        .e_rd(lane[3]),
        .se_rd(lane[4]),
        .s_rd(lane[5]),
        .sw_rd(lane[6]),
        .w_rd(lane[7]),
        .nw_rd(lane[8]),
`ifdef LATTICE_STREAM_OUT_CHECKSUM_EN
        .checksum(checksum),
`endif
        .m00_axis(axis.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: lane i = addr*9+i, one cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            for (int i = 0; i < 9; i++) begin
                lane[i] <= 16'(int'(rd_addr) * 9 + i);
            end
        end
    end

    function automatic logic [143:0] exp_beat(input int a);
        logic [143:0] r;
        int v;
        r = '0;
        for (int i = 0; i < 9; i++) begin
            v = a * 9 + i;
            r[i*16 +: 16] = v[15:0];
        end
        return r;
    endfunction

    function automatic logic [15:0] fold(input logic [143:0] d);
        logic [15:0] f;
        f = '0;
        for (int i = 0; i < 9; i++) f = f ^ d[i*16 +: 16];
        return f;
    endfunction

    // mode 0 full flow, 1 random tready, 2 long stall,
    // 3 start while busy, 4 reset at beat 700.
    task automatic run_frame(input int mode, output int beats,
                             output int done_cyc, output int done_cnt);
        int issues;
        int pops;
        int cyc;
        int stall;
        logic held_v;
        logic sent;
        logic [143:0] held;
        logic [143:0] e;
        issues = 0;
        pops = 0;
        cyc = 0;
        stall = 0;
        held_v = 1'b0;
        sent = 1'b0;
        held = '0;
        beats = 0;
        done_cyc = 0;
        done_cnt = 0;
        cks_exp = '0;
        start = 1'b1;
        axis.tready = 1'b1;
        while (cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            case (mode)
                1: axis.tready = 1'($urandom_range(0, 1));
                2: begin
                    if (beats >= 500 && stall < 100) begin
                        axis.tready = 1'b0;
                        stall++;
                    end else begin
                        axis.tready = 1'b1;
                    end
                end
                default: axis.tready = 1'b1;
            endcase
            if (mode == 3 && beats == 1000 && !sent) begin
                start = 1'b1;
                sent = 1'b1;
            end
            if (mode == 4 && beats == 700) begin
                rst_n = 1'b0;
                #1;
                total++;
                if (busy !== 1'b0 || done !== 1'b0 ||
                    rd_en !== 1'b0 || rd_addr !== '0 ||
                    axis.tvalid !== 1'b0 || axis.tlast !== 1'b0 ||
                    axis.tdata !== '0 || axis.tstrb !== '1) begin
                    bad++;
                    $display("FAIL mid_reset_outputs got busy=%b done=%b rd_en=%b addr=%0d tvalid=%b tlast=%b tdata=%h want all 0",
                             busy, done, rd_en, rd_addr, axis.tvalid,
                             axis.tlast, axis.tdata);
                end
                return;
            end
            #1;
            if (cyc == 1) begin
                total++;
                if (busy !== 1'b1 || rd_en !== 1'b1) begin
                    bad++;
                    $display("FAIL first_issue got busy=%b rd_en=%b want 1 1",
                             busy, rd_en);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = cyc;
`ifdef LATTICE_STREAM_OUT_CHECKSUM_EN
                    total++;
                    if (checksum !== cks_exp) begin
                        bad++;
                        $display("FAIL checksum_at_done got %h want %h",
                                 checksum, cks_exp);
                    end
`endif
                end
                if (mode != 3) break;
            end
            if (mode == 3 && done_cyc != 0) begin
                if (cyc >= done_cyc + 5) break;
                continue;
            end
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL busy_hold cyc=%0d got %b want 1", cyc, busy);
            end
            total++;
            if (issues - pops > 2) begin
                bad++;
                $display("FAIL occupancy cyc=%0d got %0d want <=2",
                         cyc, issues - pops);
            end
            if (mode == 0 && cyc >= 3 && cyc <= DEPTH + 2) begin
                total++;
                if (axis.tvalid !== 1'b1) begin
                    bad++;
                    $display("FAIL continuous_valid cyc=%0d got %b want 1",
                             cyc, axis.tvalid);
                end
            end
            if (mode == 2 && stall > 3 && axis.tready == 1'b0) begin
                total++;
                if (rd_en !== 1'b0 || issues - pops != 2) begin
                    bad++;
                    $display("FAIL stall_hold got rd_en=%b held=%0d want 0 2",
                             rd_en, issues - pops);
                end
            end
            if (rd_en === 1'b1) begin
                total++;
                if (rd_addr !== AW'(issues)) begin
                    bad++;
                    $display("FAIL rd_addr got %0d want %0d",
                             rd_addr, issues);
                end
                issues++;
            end
            if (axis.tvalid === 1'b1) begin
                e = exp_beat(beats);
                total++;
                if (axis.tdata !== e) begin
                    bad++;
                    $display("FAIL tdata beat=%0d got %h want %h",
                             beats, axis.tdata, e);
                end
                total++;
                if (axis.tlast !== (beats == DEPTH - 1)) begin
                    bad++;
                    $display("FAIL tlast beat=%0d got %b want %b",
                             beats, axis.tlast, beats == DEPTH - 1);
                end
                if (held_v) begin
                    total++;
                    if (axis.tdata !== held) begin
                        bad++;
                        $display("FAIL stall_stable got %h want %h",
                                 axis.tdata, held);
                    end
                end
                if (axis.tready) begin
                    cks_exp = cks_exp ^ fold(e);
                    beats++;
                    pops++;
                    held_v = 1'b0;
                end else begin
                    held = axis.tdata;
                    held_v = 1'b1;
                end
            end
        end
        if (done_cyc == 0) begin
            total++;
            bad++;
            $display("FAIL frame_timeout mode=%0d got beats=%0d want done",
                     mode, beats);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        axis.tready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0 ||
            rd_addr !== '0 || axis.tvalid !== 1'b0 ||
            axis.tlast !== 1'b0 || axis.tdata !== '0 ||
            axis.tstrb !== '1) begin
            bad++;
            $display("FAIL reset_state got busy=%b done=%b rd_en=%b tvalid=%b tstrb=%h want 0/all-ones strb",
                     busy, done, rd_en, axis.tvalid, axis.tstrb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_frame(input string name, input int beats,
                               input int dcyc, input int dcnt,
                               input bit exact);
        total++;
        if (beats != DEPTH) begin
            bad++;
            $display("FAIL %s_beats got %0d want %0d", name, beats, DEPTH);
        end
        total++;
        if (dcnt != 1) begin
            bad++;
            $display("FAIL %s_done_count got %0d want 1", name, dcnt);
        end
        if (exact) begin
            total++;
            if (dcyc != DEPTH + 3) begin
                bad++;
                $display("FAIL %s_latency got %0d want %0d",
                         name, dcyc, DEPTH + 3);
            end
        end
    endtask

    task automatic test_continuous();
        int b, dc, dn;
        run_frame(0, b, dc, dn);
        check_frame("continuous", b, dc, dn, 1'b1);
    endtask

    task automatic test_backpressure();
        int b, dc, dn;
        run_frame(1, b, dc, dn);
        check_frame("backpressure", b, dc, dn, 1'b0);
    endtask

    task automatic test_long_stall();
        int b, dc, dn;
        run_frame(2, b, dc, dn);
        check_frame("long_stall", b, dc, dn, 1'b0);
    endtask

    task automatic test_start_busy();
        int b, dc, dn;
        run_frame(3, b, dc, dn);
        check_frame("start_busy", b, dc, dn, 1'b1);
    endtask

    task automatic test_mid_reset();
        int b, dc, dn;
        run_frame(4, b, dc, dn);
        total++;
        if (b != 700) begin
            bad++;
            $display("FAIL mid_reset_point got %0d want 700", b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || axis.tvalid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle got busy=%b tvalid=%b want 0 0",
                     busy, axis.tvalid);
        end
        run_frame(0, b, dc, dn);
        check_frame("fresh_start", b, dc, dn, 1'b1);
    endtask

`ifdef LATTICE_STREAM_OUT_CHECKSUM_EN
    task automatic test_checksum();
        int n;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (checksum !== cks_exp) begin
                bad++;
                $display("FAIL checksum_hold got %h want %h",
                         checksum, cks_exp);
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if (checksum !== 16'h0000) begin
            bad++;
            $display("FAIL checksum_clear got %h want 0000", checksum);
        end
        n = 0;
        while (done !== 1'b1 && n < 10000) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL checksum_frame_timeout got done=%b want 1", done);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        cks_exp = '0;
        rst_n = 1'b0;
        start = 1'b0;
        axis.tready = 1'b0;
        test_reset();
        test_continuous();
        test_backpressure();
        test_long_stall();
        test_start_busy();
        test_mid_reset();
`ifdef LATTICE_STREAM_OUT_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
